// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - Multi-cycle MIPS control FSM driving the Datapath controls.
// Optional CTRL_INSTR_COUNT_EN adds a retired-instruction counter output o_instr_count.
module mips_multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic        i_zero,
  output logic [4:0]  o_first5bits,
  output logic [4:0]  o_second5bits,
  output logic [15:0] o_immediate,
  output logic        o_regDst,
  output logic        o_ReadWriteRF,
  output logic        o_RFSource,
  output logic        o_AluSource,
  output logic [2:0]  o_AluControl,
  output logic        o_WriteEnDataMemory,
  output logic        o_ReadEnDataMemory,
  output logic        o_MemToReg,
  output logic        o_branch,
  output logic        o_illegal,
  output logic        o_done
`ifdef CTRL_INSTR_COUNT_EN
  ,
  output logic [31:0] o_instr_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_ILLEGAL} class_t;

  state_t      state, nextState;
  class_t      instrClass, decClass;
  logic [31:0] instrReg;
  logic [2:0]  rAluCtrl;
  logic        rFunctOk;

  assign o_first5bits  = instrReg[25:21];
  assign o_second5bits = instrReg[20:16];
  assign o_immediate   = instrReg[15:0];
  assign o_RFSource    = 1'b0;

  // R-type funct decode; rFunctOk doubles as the legality check for opcode 0
  always_comb begin
    rAluCtrl = ALU_ADD;
    rFunctOk = 1'b1;
    case (instrReg[5:0])
      6'h20:   rAluCtrl = ALU_ADD;
      6'h22:   rAluCtrl = ALU_SUB;
      6'h24:   rAluCtrl = ALU_AND;
      6'h25:   rAluCtrl = ALU_OR;
      6'h2A:   rAluCtrl = ALU_SLT;
      default: rFunctOk = 1'b0;
    endcase
  end

  always_comb begin
    decClass = C_ILLEGAL;
    case (instrReg[31:26])
      6'h00:   decClass = rFunctOk ? C_RTYPE : C_ILLEGAL;
      6'h08:   decClass = C_ADDI;
      6'h23:   decClass = C_LW;
      6'h2B:   decClass = C_SW;
      6'h04:   decClass = C_BEQ;
      default: decClass = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      instrReg   <= 32'd0;
      instrClass <= C_ILLEGAL;
    end else begin
      state <= nextState;
      if (state == S_IDLE && i_instr_valid)
        instrReg <= i_instr;
      if (state == S_DECODE)
        instrClass <= decClass;
    end
  end

  always_comb begin
    nextState           = state;
    o_instr_ready       = 1'b0;
    o_regDst            = 1'b0;
    o_ReadWriteRF       = 1'b0;
    o_AluSource         = 1'b0;
    o_AluControl        = 3'b000;
    o_WriteEnDataMemory = 1'b0;
    o_ReadEnDataMemory  = 1'b0;
    o_MemToReg          = 1'b0;
    o_branch            = 1'b0;
    o_illegal           = 1'b0;
    o_done              = 1'b0;
    // ALU controls are driven from EXEC onward and held through MEM/WB
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      o_AluSource  = (instrClass == C_ADDI) || (instrClass == C_LW) || (instrClass == C_SW);
      o_AluControl = (instrClass == C_RTYPE) ? rAluCtrl :
                     (instrClass == C_BEQ)   ? ALU_SUB : ALU_ADD;
    end
    case (state)
      S_IDLE: begin
        o_instr_ready = 1'b1;
        if (i_instr_valid) nextState = S_DECODE;
      end
      S_DECODE: begin
        if (decClass == C_ILLEGAL) begin
          o_illegal = 1'b1;
          o_done    = 1'b1;
          nextState = S_IDLE;
        end else begin
          nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        if (instrClass == C_BEQ) begin
          o_branch  = i_zero;
          o_done    = 1'b1;
          nextState = S_IDLE;
        end else if (instrClass == C_LW || instrClass == C_SW) begin
          nextState = S_MEM;
        end else begin
          nextState = S_WB;
        end
      end
      S_MEM: begin
        if (instrClass == C_LW) begin
          o_ReadEnDataMemory = 1'b1;
          nextState          = S_WB;
        end else begin
          o_WriteEnDataMemory = 1'b1;
          o_done              = 1'b1;
          nextState           = S_IDLE;
        end
      end
      S_WB: begin
        o_ReadWriteRF = 1'b1;
        o_regDst      = (instrClass == C_RTYPE);
        o_MemToReg    = (instrClass == C_LW);
        o_done        = 1'b1;
        nextState     = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

`ifdef CTRL_INSTR_COUNT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_instr_count <= 32'd0;
    else if (o_done && !o_illegal)
      o_instr_count <= o_instr_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - Scoreboard bench for mips_multicycle_control.
module tb_mips_multicycle_control;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_instr;
  logic        i_instr_valid;
  logic        i_zero;
  logic        o_instr_ready, o_regDst, o_ReadWriteRF, o_RFSource, o_AluSource;
  logic        o_WriteEnDataMemory, o_ReadEnDataMemory, o_MemToReg, o_branch, o_illegal, o_done;
  logic [4:0]  o_first5bits, o_second5bits;
  logic [15:0] o_immediate;
  logic [2:0]  o_AluControl;
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] o_instr_count;
`endif

  mips_multicycle_control dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready), .i_zero(i_zero),
    .o_first5bits(o_first5bits), .o_second5bits(o_second5bits), .o_immediate(o_immediate),
    .o_regDst(o_regDst), .o_ReadWriteRF(o_ReadWriteRF), .o_RFSource(o_RFSource),
    .o_AluSource(o_AluSource), .o_AluControl(o_AluControl),
    .o_WriteEnDataMemory(o_WriteEnDataMemory), .o_ReadEnDataMemory(o_ReadEnDataMemory),
    .o_MemToReg(o_MemToReg), .o_branch(o_branch), .o_illegal(o_illegal), .o_done(o_done)
`ifdef CTRL_INSTR_COUNT_EN
    , .o_instr_count(o_instr_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  lat;
    logic        ill;
    logic        br;
    logic [1:0]  rfW;
    logic [1:0]  memR;
    logic [1:0]  memW;
    logic        regDst;
    logic        m2r;
    logic        src;
    logic [2:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic ill, input logic br,
                              input int rfW, input int memR, input int memW,
                              input logic regDst, input logic m2r, input logic src,
                              input logic [2:0] alu, input logic [31:0] ins);
    exp_t e;
    e.lat = 4'(lat); e.ill = ill; e.br = br;
    e.rfW = 2'(rfW); e.memR = 2'(memR); e.memW = 2'(memW);
    e.regDst = regDst; e.m2r = m2r; e.src = src; e.alu = alu;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.imm = ins[15:0];
    return e;
  endfunction

  // Monitor: tracks each accepted instruction from accept to o_done
  logic busy = 1'b0;
  logic pend = 1'b0;
  int   cyc  = 0;
  exp_t obs, e;
  always @(negedge i_clk) begin
    if (i_rst) begin
      busy = 1'b0;
    end else begin
      if (pend) begin busy = 1'b1; cyc = 0; obs = '0; end
      if (busy) begin
        cyc++;
        chk("rf_mem_write_overlap", {63'd0, o_ReadWriteRF & o_WriteEnDataMemory}, 64'd0);
        if (o_ReadWriteRF) begin
          obs.rfW = obs.rfW + 2'd1; obs.regDst = o_regDst; obs.m2r = o_MemToReg;
        end
        if (o_ReadEnDataMemory)  obs.memR = obs.memR + 2'd1;
        if (o_WriteEnDataMemory) obs.memW = obs.memW + 2'd1;
        if (cyc == 2) begin obs.src = o_AluSource; obs.alu = o_AluControl; obs.br = o_branch; end
        if (o_done) begin
          obs.lat = 4'(cyc); obs.ill = o_illegal;
          obs.rs = o_first5bits; obs.rt = o_second5bits; obs.imm = o_immediate;
          busy = 1'b0;
          if (expQ.size() == 0) begin
            chk("done_without_expectation", 64'd1, 64'd0);
          end else begin
            e = expQ.pop_front();
            chk("latency",  64'(obs.lat), 64'(e.lat));
            chk("illegal",  64'(obs.ill), 64'(e.ill));
            chk("branch",   64'(obs.br),  64'(e.br));
            chk("enables",  64'({obs.rfW, obs.memR, obs.memW}), 64'({e.rfW, e.memR, e.memW}));
            chk("writeback", 64'({obs.regDst, obs.m2r}), 64'({e.regDst, e.m2r}));
            chk("alu",      64'({obs.src, obs.alu}), 64'({e.src, e.alu}));
            chk("fields",   64'({obs.rs, obs.rt, obs.imm}), 64'({e.rs, e.rt, e.imm}));
          end
        end else if (cyc > 8) begin
          chk("done_timeout", 64'(cyc), 64'd0);
          busy = 1'b0;
        end
      end else if (o_done) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end
    end
    pend = !i_rst && o_instr_ready && i_instr_valid;
  end

  task automatic send(input logic [31:0] ins, input logic z, input exp_t ex, input logic hold);
    int n;
    expQ.push_back(ex);
    i_instr = ins; i_zero = z; i_instr_valid = 1'b1;
    n = 0;
    while (!o_instr_ready && n < 20) begin @(posedge i_clk); #1; n++; end
    @(posedge i_clk); #1;
    // while busy, keep valid high with a different word; it must not be taken
    if (hold) i_instr = 32'hAC44000C;
    else i_instr_valid = 1'b0;
    n = 0;
    while (!o_done && n < 20) begin @(negedge i_clk); n++; end
    if (n >= 20) chk("send_done_timeout", 64'(n), 64'd0);
    i_instr_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h00430820;
  localparam logic [31:0] I_SUB  = 32'h00430822;
  localparam logic [31:0] I_AND  = 32'h00430824;
  localparam logic [31:0] I_OR   = 32'h00430825;
  localparam logic [31:0] I_SLT  = 32'h0043082A;
  localparam logic [31:0] I_ADDI = 32'h20450010;
  localparam logic [31:0] I_LW   = 32'h8C440008;
  localparam logic [31:0] I_SW   = 32'hAC44000C;
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_BAD  = 32'hFC000000;
  localparam logic [31:0] I_ADDU = 32'h00430821;

  initial begin
    i_rst = 1'b1; i_instr = 32'd0; i_instr_valid = 1'b0; i_zero = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outputs",
        64'({o_instr_ready, o_first5bits, o_second5bits, o_immediate, o_regDst, o_ReadWriteRF,
             o_RFSource, o_AluSource, o_AluControl, o_WriteEnDataMemory, o_ReadEnDataMemory,
             o_MemToReg, o_branch, o_illegal, o_done}),
        64'({1'b1, 39'd0}));
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // lw abandoned by reset while in MEM
    i_instr = I_LW; i_instr_valid = 1'b1;
    @(posedge i_clk); #1;
    i_instr_valid = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #2;
    chk("mid_lw_read_enable", 64'(o_ReadEnDataMemory), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("reset_in_mem",
        64'({o_ReadEnDataMemory, o_WriteEnDataMemory, o_ReadWriteRF, o_done, o_instr_ready, o_first5bits}),
        64'({4'b0000, 1'b1, 5'd0}));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    send(I_ADD, 1'b0, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b010, I_ADD), 1'b0);
    send(I_LW,  1'b0, mk(4, 0, 0, 1, 1, 0, 0, 1, 1, 3'b010, I_LW),  1'b0);
    send(I_BAD, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, I_BAD), 1'b1);
    send(I_SW,  1'b0, mk(3, 0, 0, 0, 0, 1, 0, 0, 1, 3'b010, I_SW),  1'b0);
`ifdef CTRL_INSTR_COUNT_EN
    chk("instr_count", 64'(o_instr_count), 64'd3);
`endif
    send(I_BEQ,  1'b1, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 3'b110, I_BEQ),  1'b0);
    send(I_BEQ,  1'b0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 3'b110, I_BEQ),  1'b0);
    send(I_SUB,  1'b0, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b110, I_SUB),  1'b0);
    send(I_AND,  1'b0, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b000, I_AND),  1'b0);
    send(I_OR,   1'b0, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b001, I_OR),   1'b0);
    send(I_SLT,  1'b0, mk(3, 0, 0, 1, 0, 0, 1, 0, 0, 3'b111, I_SLT),  1'b1);
    send(I_ADDI, 1'b0, mk(3, 0, 0, 1, 0, 0, 0, 0, 1, 3'b010, I_ADDI), 1'b0);
    send(I_ADDU, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, I_ADDU), 1'b1);

    repeat (5) @(negedge i_clk);
    chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
